// File: rtl/mm_pkg.sv
// Shared types and helpers for the matrix-multiply engine.
package mm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        MAC,
        WR,
        DONE
    } state_e;

    localparam logic [1:0] MAT_A = 2'd0;
    localparam logic [1:0] MAT_B = 2'd1;
    localparam logic [1:0] MAT_C = 2'd2;

    // Ceiling log2, used to size the accumulator growth bits for N terms.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mm_mac.sv
// Signed multiply-accumulator with clear/enable and 2*DW output reduction.
module mm_mac
    import mm_pkg::*;
#(
    parameter int N   = 8,
    parameter int DW  = 20,
    parameter int SAT = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr_i,
    input  logic                   en_i,
    input  logic signed [DW-1:0]   a_i,
    input  logic signed [DW-1:0]   b_i,
    output logic signed [2*DW-1:0] res_o
);

    localparam int AW = 2*DW + clog2(N);
    localparam logic signed [AW-1:0] MAXV = {{(AW-2*DW+1){1'b0}}, {(2*DW-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = {{(AW-2*DW+1){1'b1}}, {(2*DW-1){1'b0}}};

    logic signed [AW-1:0]   acc_q, acc_d;
    logic signed [2*DW-1:0] a_ext, b_ext, prod;
    logic signed [AW-1:0]   prod_ext;

    // Keep the low 2*DW bits (two's-complement wrap).
    function automatic logic signed [2*DW-1:0] wrap_red(input logic signed [AW-1:0] v);
        return v[2*DW-1:0];
    endfunction

    // Clamp to the signed 2*DW range.
    function automatic logic signed [2*DW-1:0] sat_red(input logic signed [AW-1:0] v);
        if (v > MAXV) begin
            return MAXV[2*DW-1:0];
        end else if (v < MINV) begin
            return MINV[2*DW-1:0];
        end
        return v[2*DW-1:0];
    endfunction

    // The full product of two DW-bit signed values fits in 2*DW bits.
    assign a_ext    = {{DW{a_i[DW-1]}}, a_i};
    assign b_ext    = {{DW{b_i[DW-1]}}, b_i};
    assign prod     = a_ext * b_ext;
    assign prod_ext = {{(AW-2*DW){prod[2*DW-1]}}, prod};
    assign res_o    = (SAT != 0) ? sat_red(acc_q) : wrap_red(acc_q);

    // Next accumulator value: clear wins over accumulate.
    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + prod_ext;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/mm_engine.sv
// Matrix-multiply engine: walks C = A x B over a single-port synchronous memory.
module mm_engine
    import mm_pkg::*;
#(
    parameter int N   = 8,
    parameter int DW  = 20,
    parameter int IW  = 20,
    parameter int SAT = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic [IW-1:0]          i,
    output logic [IW-1:0]          j,
    output logic [1:0]             mat_sel,
    output logic                   read,
    output logic                   write,
    input  logic signed [DW-1:0]   read_data,
    output logic signed [2*DW-1:0] write_data,
    output logic                   busy,
    output logic                   finish
);

    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic [IW-1:0] ONE  = IW'(1);

    state_e                 state_q, state_d;
    logic [IW-1:0]          r_q, r_d, c_q, c_d, k_q, k_d;
    logic signed [DW-1:0]   a_q, a_d;
    logic                   finish_q;
    logic                   mac_clr, mac_en;
    logic signed [2*DW-1:0] mac_res;

    mm_mac #(.N(N), .DW(DW), .SAT(SAT)) u_mac (
        .clk   (clk),
        .rst   (reset),
        .clr_i (mac_clr),
        .en_i  (mac_en),
        .a_i   (a_q),
        .b_i   (read_data),
        .res_o (mac_res)
    );

    assign finish = finish_q;

    // Next-state, counter updates and memory strobes; strobes idle at zero.
    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        c_d        = c_q;
        k_d        = k_q;
        a_d        = a_q;
        mac_clr    = 1'b0;
        mac_en     = 1'b0;
        i          = '0;
        j          = '0;
        mat_sel    = MAT_A;
        read       = 1'b0;
        write      = 1'b0;
        write_data = '0;
        busy       = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RD_A;
                    r_d     = '0;
                    c_d     = '0;
                    k_d     = '0;
                    mac_clr = 1'b1;
                end
            end
            RD_A: begin
                busy    = 1'b1;
                read    = 1'b1;
                mat_sel = MAT_A;
                i       = r_q;
                j       = k_q;
                state_d = RD_B;
            end
            RD_B: begin
                busy    = 1'b1;
                read    = 1'b1;
                mat_sel = MAT_B;
                i       = k_q;
                j       = c_q;
                a_d     = read_data;
                state_d = MAC;
            end
            MAC: begin
                busy   = 1'b1;
                mac_en = 1'b1;
                if (k_q == LAST) begin
                    state_d = WR;
                end else begin
                    k_d     = k_q + ONE;
                    state_d = RD_A;
                end
            end
            WR: begin
                busy       = 1'b1;
                write      = 1'b1;
                mat_sel    = MAT_C;
                i          = r_q;
                j          = c_q;
                write_data = mac_res;
                k_d        = '0;
                mac_clr    = 1'b1;
                if (c_q != LAST) begin
                    c_d     = c_q + ONE;
                    state_d = RD_A;
                end else if (r_q != LAST) begin
                    c_d     = '0;
                    r_d     = r_q + ONE;
                    state_d = RD_A;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters, A operand latch; finish trails DONE entry by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            r_q      <= '0;
            c_q      <= '0;
            k_q      <= '0;
            a_q      <= '0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            c_q      <= c_d;
            k_q      <= k_d;
            a_q      <= a_d;
            finish_q <= (state_q == DONE);
        end
    end

endmodule

// File: tb/tb_mm_engine.sv
// Directed bench for mm_engine: four instances covering the main configurations.
module tb_mm_engine;

    typedef struct {
        int     i;
        int     j;
        longint d;
        int     c;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    int viol = 0;
    int n_chk = 0;
    int n_pass = 0;

    // Instance 0: N=2, DW=20, wrap
    logic start0, rd_s0, wr_s0, busy0, fin0;
    logic [19:0] i0, j0;
    logic [1:0] ms0;
    logic signed [19:0] rdat0;
    logic signed [39:0] wd0;
    // Instance 1: N=4, DW=20, wrap
    logic start1, rd_s1, wr_s1, busy1, fin1;
    logic [19:0] i1, j1;
    logic [1:0] ms1;
    logic signed [19:0] rdat1;
    logic signed [39:0] wd1;
    // Instance 2: N=2, DW=4, wrap
    logic start2, rd_s2, wr_s2, busy2, fin2;
    logic [19:0] i2, j2;
    logic [1:0] ms2;
    logic signed [3:0] rdat2;
    logic signed [7:0] wd2;
    // Instance 3: N=2, DW=4, saturate
    logic start3, rd_s3, wr_s3, busy3, fin3;
    logic [19:0] i3, j3;
    logic [1:0] ms3;
    logic signed [3:0] rdat3;
    logic signed [7:0] wd3;

    int a0 [4][4], b0 [4][4], a1 [4][4], b1 [4][4], a2 [4][4], b2 [4][4];
    wr_t q0[$], q1[$], q2[$], q3[$];
    bit pb0, pb1, pb2, pb3;

    mm_engine #(.N(2), .DW(20), .IW(20), .SAT(0)) d0 (
        .clk(clk), .reset(reset), .start(start0), .i(i0), .j(j0), .mat_sel(ms0),
        .read(rd_s0), .write(wr_s0), .read_data(rdat0), .write_data(wd0),
        .busy(busy0), .finish(fin0));
    mm_engine #(.N(4), .DW(20), .IW(20), .SAT(0)) d1 (
        .clk(clk), .reset(reset), .start(start1), .i(i1), .j(j1), .mat_sel(ms1),
        .read(rd_s1), .write(wr_s1), .read_data(rdat1), .write_data(wd1),
        .busy(busy1), .finish(fin1));
    mm_engine #(.N(2), .DW(4), .IW(20), .SAT(0)) d2 (
        .clk(clk), .reset(reset), .start(start2), .i(i2), .j(j2), .mat_sel(ms2),
        .read(rd_s2), .write(wr_s2), .read_data(rdat2), .write_data(wd2),
        .busy(busy2), .finish(fin2));
    mm_engine #(.N(2), .DW(4), .IW(20), .SAT(1)) d3 (
        .clk(clk), .reset(reset), .start(start3), .i(i3), .j(j3), .mat_sel(ms3),
        .read(rd_s3), .write(wr_s3), .read_data(rdat3), .write_data(wd3),
        .busy(busy3), .finish(fin3));

    // Memory models: data only valid the cycle after a read, garbage otherwise.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        rdat0 <= rd_s0 ? 20'(ms0 == 2'd0 ? a0[i0[1:0]][j0[1:0]] : b0[i0[1:0]][j0[1:0]]) : 20'($urandom);
        rdat1 <= rd_s1 ? 20'(ms1 == 2'd0 ? a1[i1[1:0]][j1[1:0]] : b1[i1[1:0]][j1[1:0]]) : 20'($urandom);
        rdat2 <= rd_s2 ? 4'(ms2 == 2'd0 ? a2[i2[1:0]][j2[1:0]] : b2[i2[1:0]][j2[1:0]]) : 4'($urandom);
        rdat3 <= rd_s3 ? 4'(ms3 == 2'd0 ? a2[i3[1:0]][j3[1:0]] : b2[i3[1:0]][j3[1:0]]) : 4'($urandom);
        if (wr_s0) q0.push_back('{int'(i0), int'(j0), longint'(wd0), cyc});
        if (wr_s1) q1.push_back('{int'(i1), int'(j1), longint'(wd1), cyc});
        if (wr_s2) q2.push_back('{int'(i2), int'(j2), longint'(wd2), cyc});
        if (wr_s3) q3.push_back('{int'(i3), int'(j3), longint'(wd3), cyc});
    end

    function automatic int proto(input logic rd, input logic wr, input logic [19:0] ii,
                                 input logic [19:0] jj, input int n, input bit pb);
        int v;
        v = 0;
        if (rd && wr) v++;
        if ((rd || wr) && (ii >= 20'(n) || jj >= 20'(n))) v++;
        if (pb && (rd || wr)) v++;
        return v;
    endfunction

    // Protocol monitor: B data must be consumed in a strobe-free MAC cycle.
    always @(negedge clk) begin
        viol <= viol + proto(rd_s0, wr_s0, i0, j0, 2, pb0) + proto(rd_s1, wr_s1, i1, j1, 4, pb1)
                     + proto(rd_s2, wr_s2, i2, j2, 2, pb2) + proto(rd_s3, wr_s3, i3, j3, 2, pb3);
        pb0 <= rd_s0 && (ms0 == 2'd1);
        pb1 <= rd_s1 && (ms1 == 2'd1);
        pb2 <= rd_s2 && (ms2 == 2'd1);
        pb3 <= rd_s3 && (ms3 == 2'd1);
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Start instance 0, wait for finish; report latency, finish after 2 cycles, busy after 1.
    task automatic run0(input bit pulse, output int lat, output logic f1, output logic b1v);
        int t0;
        lat = -1;
        f1 = 1'bx;
        b1v = 1'bx;
        q0.delete();
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        start0 = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (n == 0) b1v = busy0;
            if (n == 1) f1 = fin0;
            if (fin0 && n > 0) begin
                lat = cyc - t0;
                break;
            end
            if (pulse) start0 = busy0 ? ~start0 : 1'b0;
        end
        start0 = 1'b0;
    endtask

    task automatic chk_c0(input string tag);
        longint e[4];
        e = '{19, 22, 43, 50};
        chk({tag, "_nwr"}, q0.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_ij%0d", tag, k), q0[k].i * 2 + q0[k].j, k);
            chk($sformatf("%s_c%0d", tag, k), q0[k].d, e[k]);
        end
    endtask

    // Start instances 2 and 3 together and wait for both to finish.
    task automatic run23(output int lat);
        int t0;
        lat = -1;
        q2.delete();
        q3.delete();
        @(negedge clk);
        start2 = 1'b1;
        start3 = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        start2 = 1'b0;
        start3 = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (fin2 && fin3 && n > 0) begin
                lat = cyc - t0;
                break;
            end
        end
    endtask

    task automatic chk_c23(input string tag, input longint e2, input longint e3);
        chk({tag, "_n2"}, q2.size(), 4);
        chk({tag, "_n3"}, q3.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_wrap%0d", tag, k), q2[k].d, e2);
            chk($sformatf("%s_sat%0d", tag, k), q3[k].d, e3);
        end
    endtask

    initial begin
        int lat;
        int bad;
        int t0;
        logic f1, bv;
        int bvals [16];
        bvals = '{5, -3, 524287, -524288, 0, 1, -1, 100,
                  -77, 12345, -20000, 7, 300000, -300000, 2, -9};
        start0 = 0; start1 = 0; start2 = 0; start3 = 0;
        reset = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                a0[r][c] = 0; b0[r][c] = 0;
                a1[r][c] = (r == c) ? 1 : 0;
                b1[r][c] = bvals[r*4 + c];
                a2[r][c] = -8; b2[r][c] = -8;
            end
        end
        a0[0][0] = 1; a0[0][1] = 2; a0[1][0] = 3; a0[1][1] = 4;
        b0[0][0] = 5; b0[0][1] = 6; b0[1][0] = 7; b0[1][1] = 8;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out0", {busy0, fin0, rd_s0, wr_s0, ms0, (i0 != 0), (j0 != 0), (wd0 != 0)}, 0);
        chk("rst_out3", {busy3, fin3, rd_s3, wr_s3, ms3, (i3 != 0), (j3 != 0), (wd3 != 0)}, 0);
        reset = 1'b0;

        // 2x2 basic product
        run0(1'b0, lat, f1, bv);
        chk("n2_lat", lat, 29);
        chk_c0("run1");

        // Restart from DONE with start toggling while busy
        run0(1'b1, lat, f1, bv);
        chk("rerun_busy", bv, 1);
        chk("rerun_fin_drop", f1, 0);
        chk("rerun_lat", lat, 29);
        chk_c0("run2");

        // Reset during MAC of element (1,0)
        q0.delete();
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (16) @(posedge clk);
        @(negedge clk);
        chk("mid_busy", busy0, 1);
        chk("mid_nwr", q0.size(), 2);
        reset = 1'b1;
        #1;
        chk("async_rst", {busy0, fin0, rd_s0, wr_s0, ms0, (i0 != 0), (j0 != 0), (wd0 != 0)}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("post_rst_nwr", q0.size(), 2);
        chk("post_rst_fin", fin0, 0);
        run0(1'b0, lat, f1, bv);
        chk("fresh_lat", lat, 29);
        chk_c0("fresh");

        // 4x4 identity times B
        q1.delete();
        lat = -1;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        start1 = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (fin1) begin
                lat = cyc - t0;
                break;
            end
        end
        chk("id_lat", lat, 209);
        chk("id_nwr", q1.size(), 16);
        chk("id_first_wr", q1[0].c - t0, 12);
        bad = 0;
        for (int e = 0; e < 16; e++) begin
            chk($sformatf("id_c%0d", e), q1[e].d, bvals[e]);
            if (q1[e].i * 4 + q1[e].j != e) bad++;
            if (e > 0 && q1[e].c - q1[e-1].c != 13) bad++;
        end
        chk("id_order_pitch", bad, 0);

        // DW=4 overflow: (-8)(-8)*2 = 128
        run23(lat);
        chk("ov_lat", lat, 29);
        chk_c23("ov", -128, 127);

        // DW=4 in range: 7*(-8)*2 = -112
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                a2[r][c] = 7;
                b2[r][c] = -8;
            end
        end
        run23(lat);
        chk("inr_lat", lat, 29);
        chk_c23("inr", -112, -112);

        @(negedge clk);
        chk("protocol", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mm_engine.md
Name: mm_engine

Overview:
Parametrised matrix-multiply engine computing C = A x B for square N x N signed matrices held in an external single-port synchronous memory. Walks indices (i, j) over the memory interface, multiply-accumulates one output element at a time and writes each result back. Signals completion with finish. Generalises the fixed 20-bit MM controller in dimension, data width and overflow mode.

Parameters:
N, 8, matrix dimension (2..256); N <= 2**IW required.
DW, 20, signed element width of A and B.
IW, 20, width of the i/j index outputs.
SAT, 0, 0 = result wraps modulo 2**(2*DW); 1 = result saturates to signed 2*DW range.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  begin a run; sampled only in IDLE or DONE.
i  output  IW  row index of current memory access.
j  output  IW  column index of current memory access.
mat_sel  output  2  matrix selected: 0 = A, 1 = B, 2 = C.
read  output  1  memory read strobe.
write  output  1  memory write strobe.
read_data  input  DW  signed data; valid the cycle after read=1.
write_data  output  2*DW  signed result for C[i][j]; valid when write=1.
busy  output  1  high from first RD_A to last WR inclusive.
finish  output  1  high in DONE.

Behaviour:
- Reset (async, any state): state=IDLE; i=j=0, mat_sel=0, read=write=0, write_data=0, busy=0, finish=0; r,c,k counters, acc and a_reg cleared. Any in-flight run is abandoned; no partial write is issued.
- States: IDLE, RD_A, RD_B, MAC, WR, DONE.
- IDLE: all strobes 0. start=1 -> RD_A with r=c=k=0, acc=0.
- RD_A: read=1, mat_sel=0, i=r, j=k -> RD_B.
- RD_B: read=1, mat_sel=1, i=k, j=c; a_reg <= read_data (A[r][k]) -> MAC.
- MAC: read=0; acc <= acc + a_reg*read_data (B[k][c]), full precision (2*DW+clog2(N) bits, signed).
  - k<N-1: k++ -> RD_A.
  - k==N-1: -> WR.
- WR: write=1, mat_sel=2, i=r, j=c, write_data = acc reduced to 2*DW bits (SAT=0: low bits; SAT=1: clamp to [-2**(2*DW-1), 2**(2*DW-1)-1]). Then k=0, acc=0.
  - c<N-1: c++ -> RD_A.
  - c==N-1, r<N-1: c=0, r++ -> RD_A.
  - r==c==N-1: -> DONE.
- DONE: finish=1, busy=0, strobes 0. Held until start=1 -> RD_A (new run, counters cleared), or reset.
- Row-major output order. Cycles per element = 3N+1. With start sampled at edge t, finish first high at t + N*N*(3N+1) + 1.
- start while busy is ignored.
- read and write are never both 1. When not asserted, i/j/mat_sel hold 0.

Decomposition:
- Package mm_pkg: state enum (IDLE..DONE), mat_sel encodings MAT_A/MAT_B/MAT_C, clog2 helper for accumulator width.
- One sub-module: mm_mac.
  - Registered signed accumulator with clear, enable and 2*DW output reduction.
  - Reduction is wrap or saturate per SAT.
  - The FSM and counters stay in mm_engine.

Test Plan:
- N=2, DW=20: A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> writes C[0][0]=19, C[0][1]=22, C[1][0]=43, C[1][1]=50, in that order; finish high exactly 29 cycles after start edge.
- N=4, A=identity, B random signed -> C equals B element-for-element. Each element occupies 13 cycles.
- N=2, DW=4, all elements -8:
  - SAT=0 -> every C = -128 (0x80).
  - SAT=1 -> every C = 127.
  - Also A all 7, B all -8 -> -112 in both modes.
- Reset asserted during MAC of element (1,0), N=2 -> outputs zero immediately, no further write. A fresh start then produces the correct full result.
- start pulsed repeatedly while busy -> no effect on sequence or cycle count. start in DONE -> finish drops next cycle and a second run repeats identical writes.
- Protocol monitor across all runs:
  - read and write never both high.
  - Each read_data is consumed exactly one cycle after its read.
  - i/j stay below N on every strobe.
